// File: rtl/ay_bus_seq.sv
// AY-3-8910 bus sequencer: queues host register accesses and plays them out as
// timed BDIR/BC1/BC2 + DA bus cycles, skipping the address phase when it is already latched.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | nothing in flight, bus inactive, DA released
// S_A_SET  | address on DA, bus inactive (setup before latch)
// S_A_LAT  | latch-address code held for ADDR_CYC clocks
// S_A_HOLD | bus inactive, address still driven (hold after latch)
// S_D_SET  | bus inactive, write data driven or DA released for a read
// S_D_XFER | write or read code held for WR_CYC / RD_CYC clocks
// S_D_HOLD | bus inactive for GAP_CYC clocks, then next request or idle
module ay_bus_seq #(
    parameter int ADDR_CYC   = 2,
    parameter int WR_CYC     = 3,
    parameter int RD_CYC     = 3,
    parameter int GAP_CYC    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [3:0] req_reg,
    input  logic [7:0] req_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       ay_bdir,
    output logic       ay_bc1,
    output logic       ay_bc2,
    output logic [7:0] ay_da_out,
    output logic       ay_da_oe,
    input  logic [7:0] ay_da_in
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max2(max2(ADDR_CYC, WR_CYC), max2(RD_CYC, GAP_CYC));
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int NW      = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] CODE_INACT = 3'b001;
    localparam logic [2:0] CODE_LATCH = 3'b111;
    localparam logic [2:0] CODE_WRITE = 3'b101;
    localparam logic [2:0] CODE_READ  = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_SET,
        S_A_LAT,
        S_A_HOLD,
        S_D_SET,
        S_D_XFER,
        S_D_HOLD
    } state_t;

    typedef struct packed {
        logic       rd;
        logic [3:0] regn;
        logic [7:0] data;
    } req_t;

    req_t          fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [NW-1:0] count_q;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    code_q;
    logic          da_oe_q;
    logic [7:0]    da_out_q;
    logic          rd_valid_q;
    logic [7:0]    rd_data_q;
    logic          wrk_rd_q;
    logic [3:0]    wrk_reg_q;
    logic [7:0]    wrk_data_q;
    logic          cache_valid_q;
    logic [3:0]    cache_reg_q;

    req_t head;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic cache_hit;
    logic last_cnt;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == NW'(FIFO_DEPTH));
    assign req_ready  = !fifo_full;
    // Full is judged on the registered count, so a same-clock pop never frees a slot early.
    assign push       = req_valid && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q];
    assign last_cnt   = (cnt_q == CW'(1));
    assign pop        = !fifo_empty &&
                        ((state_q == S_IDLE) || ((state_q == S_D_HOLD) && last_cnt));
    assign cache_hit  = cache_valid_q && (head.regn == cache_reg_q);

    assign busy      = (state_q != S_IDLE) || !fifo_empty;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign ay_bdir   = code_q[2];
    assign ay_bc1    = code_q[1];
    assign ay_bc2    = code_q[0];
    assign ay_da_out = da_out_q;
    assign ay_da_oe  = da_oe_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {req_rd, req_reg, req_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + NW'(1);
                2'b01:   count_q <= count_q - NW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            code_q        <= CODE_INACT;
            da_oe_q       <= 1'b0;
            da_out_q      <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            wrk_rd_q      <= 1'b0;
            wrk_reg_q     <= '0;
            wrk_data_q    <= '0;
            cache_valid_q <= 1'b0;
            cache_reg_q   <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    code_q  <= CODE_INACT;
                    da_oe_q <= 1'b0;
                end
                S_A_SET: begin
                    state_q <= S_A_LAT;
                    code_q  <= CODE_LATCH;
                    cnt_q   <= CW'(ADDR_CYC);
                end
                S_A_LAT: begin
                    if (last_cnt) begin
                        state_q       <= S_A_HOLD;
                        code_q        <= CODE_INACT;
                        cache_reg_q   <= wrk_reg_q;
                        cache_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_A_HOLD: begin
                    state_q <= S_D_SET;
                    code_q  <= CODE_INACT;
                    da_oe_q <= !wrk_rd_q;
                    if (!wrk_rd_q) begin
                        da_out_q <= wrk_data_q;
                    end
                end
                S_D_SET: begin
                    state_q <= S_D_XFER;
                    code_q  <= wrk_rd_q ? CODE_READ : CODE_WRITE;
                    cnt_q   <= wrk_rd_q ? CW'(RD_CYC) : CW'(WR_CYC);
                end
                S_D_XFER: begin
                    if (last_cnt) begin
                        state_q <= S_D_HOLD;
                        code_q  <= CODE_INACT;
                        cnt_q   <= CW'(GAP_CYC);
                        if (wrk_rd_q) begin
                            rd_data_q  <= ay_da_in;
                            rd_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_D_HOLD: begin
                    if (!last_cnt) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (!pop) begin
                        state_q <= S_IDLE;
                        da_oe_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    code_q  <= CODE_INACT;
                    da_oe_q <= 1'b0;
                end
            endcase

            // Launching the next request takes priority over the per-state updates above.
            if (pop) begin
                wrk_rd_q   <= head.rd;
                wrk_reg_q  <= head.regn;
                wrk_data_q <= head.data;
                code_q     <= CODE_INACT;
                if (cache_hit) begin
                    state_q <= S_D_SET;
                    da_oe_q <= !head.rd;
                    if (!head.rd) begin
                        da_out_q <= head.data;
                    end
                end else begin
                    state_q  <= S_A_SET;
                    da_oe_q  <= 1'b1;
                    da_out_q <= {4'b0000, head.regn};
                end
            end
        end
    end

endmodule

// File: tb/tb_ay_bus_seq.sv
// Directed bench for ay_bus_seq with default timing parameters:
// full and cached writes/reads, FIFO burst with back-pressure, cache tracking, async reset.
module tb_ay_bus_seq;

    localparam logic [2:0] C_INACT = 3'b001;
    localparam logic [2:0] C_LATCH = 3'b111;
    localparam logic [2:0] C_WRITE = 3'b101;
    localparam logic [2:0] C_READ  = 3'b011;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_rd;
    logic [3:0] req_reg;
    logic [7:0] req_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       ay_bdir;
    logic       ay_bc1;
    logic       ay_bc2;
    logic [7:0] ay_da_out;
    logic       ay_da_oe;
    logic [7:0] ay_da_in;

    int n_vec;
    int n_err;

    logic [2:0] bus_code;
    assign bus_code = {ay_bdir, ay_bc1, ay_bc2};

    ay_bus_seq dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .ay_bdir   (ay_bdir),
        .ay_bc1    (ay_bc1),
        .ay_bc2    (ay_bc2),
        .ay_da_out (ay_da_out),
        .ay_da_oe  (ay_da_oe),
        .ay_da_in  (ay_da_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("bus_legal", 32'(bus_code inside {C_INACT, C_LATCH, C_WRITE, C_READ}), 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic phase(input string tag, input int n, input logic [2:0] code,
                         input logic oe, input logic [7:0] da, input logic rv);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s[%0d].code", tag, i), 32'(bus_code), 32'(code));
            chk($sformatf("%s[%0d].oe", tag, i), 32'(ay_da_oe), 32'(oe));
            if (oe) begin
                chk($sformatf("%s[%0d].da", tag, i), 32'(ay_da_out), 32'(da));
            end
            chk($sformatf("%s[%0d].rd_valid", tag, i), 32'(rd_valid), 32'(rv));
            chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'd1);
        end
    endtask

    task automatic send(input logic rd, input logic [3:0] r, input logic [7:0] d);
        chk("send.ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_rd    = rd;
        req_reg   = r;
        req_data  = d;
        tick();
        req_valid = 1'b0;
        chk("send.busy", 32'(busy), 32'd1);
    endtask

    task automatic idle_chk(input string tag);
        tick();
        chk({tag, ".code"}, 32'(bus_code), 32'(C_INACT));
        chk({tag, ".oe"}, 32'(ay_da_oe), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
    endtask

    task automatic full_write(input string tag, input logic [3:0] r, input logic [7:0] d);
        send(1'b0, r, d);
        phase({tag, ".a_set"}, 1, C_INACT, 1'b1, {4'h0, r}, 1'b0);
        phase({tag, ".a_lat"}, 2, C_LATCH, 1'b1, {4'h0, r}, 1'b0);
        phase({tag, ".a_hold"}, 1, C_INACT, 1'b1, {4'h0, r}, 1'b0);
        phase({tag, ".d_set"}, 1, C_INACT, 1'b1, d, 1'b0);
        phase({tag, ".d_xfer"}, 3, C_WRITE, 1'b1, d, 1'b0);
        phase({tag, ".d_hold"}, 1, C_INACT, 1'b1, d, 1'b0);
        idle_chk({tag, ".idle"});
    endtask

    task automatic cached_write(input string tag, input logic [3:0] r, input logic [7:0] d);
        send(1'b0, r, d);
        phase({tag, ".d_set"}, 1, C_INACT, 1'b1, d, 1'b0);
        phase({tag, ".d_xfer"}, 3, C_WRITE, 1'b1, d, 1'b0);
        phase({tag, ".d_hold"}, 1, C_INACT, 1'b1, d, 1'b0);
        idle_chk({tag, ".idle"});
    endtask

    initial begin
        int         idx;
        int         j;
        int         p;
        logic       prev_rdy;
        logic       exp_rdy;
        logic [2:0] exp_code;
        logic [7:0] exp_da;

        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_rd    = 1'b0;
        req_reg   = 4'h0;
        req_data  = 8'h00;
        ay_da_in  = 8'h00;

        tick();
        tick();
        chk("rst.code", 32'(bus_code), 32'(C_INACT));
        chk("rst.oe", 32'(ay_da_oe), 32'd0);
        chk("rst.da", 32'(ay_da_out), 32'd0);
        chk("rst.rd_valid", 32'(rd_valid), 32'd0);
        chk("rst.rd_data", 32'(rd_data), 32'd0);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle_chk("post_rst");

        // Single write after reset runs the full 9-clock sequence.
        full_write("wr7a", 4'd7, 8'h38);
        // Same register again: address phase skipped, 5 clocks.
        cached_write("wr7b", 4'd7, 8'h3F);

        // Read reg 14 (not cached).
        ay_da_in = 8'hA5;
        send(1'b1, 4'd14, 8'hFF);
        phase("rd14.a_set", 1, C_INACT, 1'b1, 8'h0E, 1'b0);
        phase("rd14.a_lat", 2, C_LATCH, 1'b1, 8'h0E, 1'b0);
        phase("rd14.a_hold", 1, C_INACT, 1'b1, 8'h0E, 1'b0);
        phase("rd14.d_set", 1, C_INACT, 1'b0, 8'h00, 1'b0);
        phase("rd14.d_xfer", 3, C_READ, 1'b0, 8'h00, 1'b0);
        phase("rd14.d_hold", 1, C_INACT, 1'b0, 8'h00, 1'b1);
        chk("rd14.rd_data", 32'(rd_data), 32'hA5);
        ay_da_in = 8'h5A;
        idle_chk("rd14.idle");
        chk("rd14.rd_data_held", 32'(rd_data), 32'hA5);

        // Cached read of reg 14.
        ay_da_in = 8'h3C;
        send(1'b1, 4'd14, 8'h00);
        phase("rd14c.d_set", 1, C_INACT, 1'b0, 8'h00, 1'b0);
        phase("rd14c.d_xfer", 3, C_READ, 1'b0, 8'h00, 1'b0);
        phase("rd14c.d_hold", 1, C_INACT, 1'b0, 8'h00, 1'b1);
        chk("rd14c.rd_data", 32'(rd_data), 32'h3C);
        idle_chk("rd14c.idle");

        // Burst of six writes to regs 1..6, data 0x11..0x66, offered every clock.
        req_rd    = 1'b0;
        req_reg   = 4'd1;
        req_data  = 8'h11;
        req_valid = 1'b1;
        idx       = 0;
        prev_rdy  = 1'b1;
        for (int k = 0; k <= 55; k++) begin
            tick();
            if (req_valid && prev_rdy) begin
                idx++;
                if (idx == 6) begin
                    req_valid = 1'b0;
                end else begin
                    req_reg  = 4'(idx + 1);
                    req_data = 8'(8'h11 * (idx + 1));
                end
            end
            exp_rdy = !((k >= 4 && k <= 9) || (k >= 11 && k <= 18));
            chk($sformatf("burst[%0d].ready", k), 32'(req_ready), 32'(exp_rdy));
            prev_rdy = exp_rdy;
            if (k >= 1 && k <= 54) begin
                j = (k - 1) / 9;
                p = (k - 1) % 9;
                if (p == 1 || p == 2)      exp_code = C_LATCH;
                else if (p >= 5 && p <= 7) exp_code = C_WRITE;
                else                       exp_code = C_INACT;
                exp_da = (p <= 3) ? 8'(j + 1) : 8'(8'h11 * (j + 1));
                chk($sformatf("burst[%0d].code", k), 32'(bus_code), 32'(exp_code));
                chk($sformatf("burst[%0d].oe", k), 32'(ay_da_oe), 32'd1);
                chk($sformatf("burst[%0d].da", k), 32'(ay_da_out), 32'(exp_da));
                chk($sformatf("burst[%0d].busy", k), 32'(busy), 32'd1);
            end else if (k == 0) begin
                chk("burst[0].busy", 32'(busy), 32'd1);
            end else begin
                chk("burst.end.code", 32'(bus_code), 32'(C_INACT));
                chk("burst.end.oe", 32'(ay_da_oe), 32'd0);
                chk("burst.end.busy", 32'(busy), 32'd0);
            end
        end
        chk("burst.accepted", 32'(idx), 32'd6);

        // Alternating registers each latch their address; then reg 0 is cached.
        full_write("alt0", 4'd0, 8'hA0);
        full_write("alt1", 4'd1, 8'hA1);
        full_write("alt0b", 4'd0, 8'hA2);
        cached_write("alt0c", 4'd0, 8'hA3);

        // Asynchronous reset in the middle of an A_LAT phase.
        send(1'b0, 4'd3, 8'h33);
        phase("rstmid.a_set", 1, C_INACT, 1'b1, 8'h03, 1'b0);
        phase("rstmid.a_lat", 1, C_LATCH, 1'b1, 8'h03, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid.code", 32'(bus_code), 32'(C_INACT));
        chk("rstmid.oe", 32'(ay_da_oe), 32'd0);
        chk("rstmid.da", 32'(ay_da_out), 32'd0);
        chk("rstmid.rd_data", 32'(rd_data), 32'd0);
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        idle_chk("rstmid.after");
        chk("rstmid.after.ready", 32'(req_ready), 32'd1);
        // Reg 0 was cached before reset; the cache must have been cleared.
        full_write("post_rst_wr0", 4'd0, 8'h77);
        chk("final.rd_data", 32'(rd_data), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ay_bus_seq.md
Name: ay_bus_seq

Overview:
Sequencer that turns host register-access requests into correctly timed AY-3-8910 bus cycles on BDIR/BC1/BC2 and the DA bus.
- A small request FIFO absorbs bursts from the host (CPU port or player engine).
- An FSM runs latch-address / write / read phases with programmable clock lengths.
- The address phase is skipped when the target register is already latched in the PSG.
- The block sits between the host-side register interface and the PSG pins, replacing ad-hoc strobe decoding.

Parameters:
- ADDR_CYC, 2: clocks the latch-address code is held (>=1).
- WR_CYC, 3: clocks the write code is held (>=1).
- RD_CYC, 3: clocks the read code is held (>=1).
- GAP_CYC, 1: inactive clocks after each data phase (>=1).
- FIFO_DEPTH, 4: request FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  host offers a request.
- req_ready  out  1  FIFO can accept; transfer when req_valid & req_ready at a clk edge.
- req_rd  in  1  1 = read, 0 = write.
- req_reg  in  4  PSG register number 0..15.
- req_data  in  8  write data (ignored for reads).
- rd_valid  out  1  one-clock pulse; rd_data valid.
- rd_data  out  8  last read result, held until next read.
- busy  out  1  FSM not IDLE or FIFO not empty.
- ay_bdir  out  1  PSG BDIR.
- ay_bc1  out  1  PSG BC1.
- ay_bc2  out  1  PSG BC2.
- ay_da_out  out  8  DA bus drive value.
- ay_da_oe  out  1  DA bus output enable.
- ay_da_in  in  8  DA bus sampled value.

Behaviour:
- Bus codes {bdir,bc1,bc2}: INACT=001, LATCH=111, WRITE=101, READ=011. No other code is ever driven. All PSG outputs are registered.
- Reset (async, immediate): codes=INACT, da_oe=0, da_out=0, rd_valid=0, rd_data=0, FIFO emptied, addr-cache invalid, FSM=IDLE, req_ready=1, busy=0.
- Reset mid-cycle aborts the PSG phase instantly; the request is lost and not retried.
- FIFO:
  - req_ready = !full, from registered count only.
  - No push when full, even if a pop occurs in the same clock.
  - Simultaneous push+pop when not full keeps the count unchanged.
  - Order is strictly FIFO.
- FSM states: IDLE, A_SET, A_LAT, A_HOLD, D_SET, D_XFER, D_HOLD.
- IDLE: if FIFO non-empty, pop the head into the working registers. Next state:
  - D_SET if cache_valid & head.reg == cache_reg;
  - else A_SET.
- A_SET (1 clk): INACT, da_oe=1, da_out={4'b0,reg}.
- A_LAT (ADDR_CYC clk): LATCH, da_oe=1, da_out held. On exit: cache_reg <= reg, cache_valid <= 1.
- A_HOLD (1 clk): INACT, da_oe=1, da_out held (hold time).
- D_SET (1 clk): INACT. Write: da_oe=1, da_out=data. Read: da_oe=0.
- D_XFER (WR_CYC or RD_CYC clk): WRITE or READ code, da_oe as in D_SET. Read: rd_data <= ay_da_in on the edge leaving D_XFER.
- D_HOLD (GAP_CYC clk): INACT.
  - Write: da_oe=1 and data held.
  - Read: da_oe=0, and rd_valid=1 in the first D_HOLD clock only.
  - On exit: pop the next entry directly into A_SET or D_SET (same rule as IDLE) if FIFO non-empty, else go to IDLE.
- IDLE outputs: INACT, da_oe=0, da_out unchanged.
- Timing (request accepted at edge E0, FIFO empty, FSM IDLE): A_SET outputs appear after edge E0+1.
  - Full write: 1+ADDR_CYC+1+1+WR_CYC+GAP_CYC = 9 clocks with defaults.
  - Cached write: 1+WR_CYC+GAP_CYC = 5 clocks.
  - Reads are the same with RD_CYC.
- Back-to-back requests: no extra IDLE cycle between requests.
- Reads also update the cache (address phase precedes them). A read to a cached register skips the address phase.
- Counters: sized to hold max(ADDR_CYC,WR_CYC,RD_CYC,GAP_CYC). Counts down to 1, then the state advances.

Test Plan:
- Reset: assert rst asynchronously mid-A_LAT → codes 001, da_oe=0 the same instant; after release busy=0, req_ready=1, and the next write to the same reg still runs the address phase (cache cleared).
- Single write reg7=0x38 after reset → after E0+1: 001/oe/0x07 for 1 clk, 111 for 2 clk, 001 for 1 clk, 001/oe/0x38 for 1 clk, 101 for 3 clk, 001 for 1 clk; then IDLE, busy=0 at clock 9.
- Second write reg7=0x3F → no 111 code; 001/oe/0x3F for 1 clk, 101 for 3 clk, 001 for 1 clk; total 5 clocks.
- Read reg14 with ay_da_in=0xA5 during READ → 111 phase with da_out=0x0E, then 011 for 3 clk with da_oe=0; rd_valid pulses exactly 1 clk with rd_data=0xA5; rd_data holds afterwards.
- Burst of 6 writes offered every clock (FIFO_DEPTH=4) → req_ready drops to 0 when the count reaches 4; no push accepted while full; all 6 execute in order with no IDLE gap; bus code never outside {001,111,101,011}.
- Alternating regs 0,1,0 → every request runs the address phase; cache_reg tracks the last latched register.
